// File: rtl/conv_frame_collector.sv
// Sink of the convolution pipeline: saturates each valid result to OUT_W bits and
// packs one frame of (M-K+1)x(N-K+1) outputs into a host-readable buffer.
module conv_frame_collector #(
    parameter int N      = 5,
    parameter int M      = 5,
    parameter int K      = 3,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       pxl_in,
    input  logic              pxl_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int TOTAL = (M - K + 1) * (N - K + 1);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);
    localparam logic [31:0]     MAXV    = (32'd1 << OUT_W) - 32'd1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Clamp a signed 32-bit result into the unsigned output pixel range.
    function automatic logic [OUT_W-1:0] sat(input logic [31:0] x);
        logic [OUT_W-1:0] r;
        if ($signed(x) < $signed(32'sd0)) begin
            r = '0;
        end else if (x > MAXV) begin
            r = MAXV[OUT_W-1:0];
        end else begin
            r = x[OUT_W-1:0];
        end
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [OUT_W-1:0]  rd_data_q, rd_data_d;
    logic              we_s;
    logic [ADDR_W:0]   wr_inc_s;
    logic [OUT_W-1:0]  wr_word_s;
    logic [OUT_W-1:0]  mem_q [DEPTH];

    assign wr_inc_s  = {1'b0, wr_count_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign wr_word_s = sat(pxl_in);

    // Frame-capture control; start overrides any same-cycle beat.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        we_s       = 1'b0;
        if (start) begin
            state_d    = ST_COLLECT;
            wr_count_d = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (pxl_valid) begin
                        we_s       = 1'b1;
                        wr_count_d = wr_inc_s[ADDR_W-1:0];
                        if (wr_inc_s == TOTAL_W) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    if (pxl_valid) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_COLLECT);
    end

    // Read port: out-of-frame addresses return zero.
    always_comb begin
        if ({1'b0, rd_addr} < TOTAL_W) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = '0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Frame buffer; the read register samples the pre-write word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we_s) begin
                mem_q[wr_count_q] <= wr_word_s;
            end else begin
                mem_q[wr_count_q] <= mem_q[wr_count_q];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign wr_count = wr_count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
